// File: rtl/br_pkg.sv
// Shared types for the D-stage branch controller: opcodes, comparator codes, FSM states.
package br_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6
    } br_op_e;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } br_state_e;

    // Encoding 7 is reserved and treated like BR_NONE.
    function automatic logic is_branch(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction

    function automatic logic uses_rt(input logic [2:0] op);
        return (op == BR_BEQ) || (op == BR_BNE);
    endfunction

endpackage

// File: rtl/d_branch_ctrl_if.sv
// D-stage branch bus: decode/forwarding inputs and resolution outputs.
// Statistics signals exist only when BR_STATS_EN is defined.
interface d_branch_ctrl_if;
    logic        d_valid;
    logic [2:0]  d_br_op;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [31:0] rs_rdata;
    logic [31:0] rt_rdata;
    logic [4:0]  e_wreg;
    logic [4:0]  m_wreg;
    logic [1:0]  e_tnew;
    logic [1:0]  m_tnew;
    logic [31:0] e_fdata;
    logic [31:0] m_fdata;
    logic        stall;
    logic        br_taken;
    logic        res_valid;
    logic        res_taken;
    logic        wd_err;
`ifdef BR_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_ntaken;
`endif

    modport master (
        output d_valid, d_br_op, d_rs, d_rt, rs_rdata, rt_rdata,
               e_wreg, m_wreg, e_tnew, m_tnew, e_fdata, m_fdata,
        input  stall, br_taken, res_valid, res_taken, wd_err
`ifdef BR_STATS_EN
        , stat_taken, stat_ntaken
`endif
    );

    modport slave (
        input  d_valid, d_br_op, d_rs, d_rt, rs_rdata, rt_rdata,
               e_wreg, m_wreg, e_tnew, m_tnew, e_fdata, m_fdata,
        output stall, br_taken, res_valid, res_taken, wd_err
`ifdef BR_STATS_EN
        , stat_taken, stat_ntaken
`endif
    );

endinterface

// File: rtl/br_cmp.sv
// Signed 32-bit comparator: A vs B and A vs 0, each as a 2-bit EQ/GT/LT code.
module br_cmp
    import br_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [1:0]  ab_code,
    output logic [1:0]  az_code
);

    always_comb begin
        ab_code = CMP_EQ;
        if ($signed(a) > $signed(b))
            ab_code = CMP_GT;
        else if ($signed(a) < $signed(b))
            ab_code = CMP_LT;

        az_code = CMP_EQ;
        if ($signed(a) > 32'sd0)
            az_code = CMP_GT;
        else if ($signed(a) < 32'sd0)
            az_code = CMP_LT;
    end

endmodule

// File: rtl/d_branch_ctrl.sv
// D-stage branch resolution: operand forwarding, hazard stall, condition decode,
// registered result record and stall watchdog. Optional counters under BR_STATS_EN.
module d_branch_ctrl
    import br_pkg::*;
#(
    parameter int WAIT_MAX = 3
) (
    input  logic            clk,
    input  logic            reset,
    d_branch_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    br_state_e      state, state_nxt;
    logic [CW-1:0]  wait_cnt, wait_cnt_nxt;
    logic [31:0]    op_a, op_b;
    logic [1:0]     ab_code, az_code;
    logic           is_br, hz_rs, hz_rt, cond, resolve, wd_set;

    // E wins over M; $0 always reads as zero.
    always_comb begin
        op_a = bus.rs_rdata;
        if (bus.d_rs == 5'd0)
            op_a = '0;
        else if (bus.e_wreg == bus.d_rs && bus.e_tnew == 2'd0)
            op_a = bus.e_fdata;
        else if (bus.m_wreg == bus.d_rs && bus.m_tnew == 2'd0)
            op_a = bus.m_fdata;

        op_b = bus.rt_rdata;
        if (bus.d_rt == 5'd0)
            op_b = '0;
        else if (bus.e_wreg == bus.d_rt && bus.e_tnew == 2'd0)
            op_b = bus.e_fdata;
        else if (bus.m_wreg == bus.d_rt && bus.m_tnew == 2'd0)
            op_b = bus.m_fdata;
    end

    always_comb begin
        is_br = is_branch(bus.d_br_op);
        hz_rs = (bus.d_rs != 5'd0) &&
                ((bus.e_wreg == bus.d_rs && bus.e_tnew != 2'd0) ||
                 (bus.m_wreg == bus.d_rs && bus.m_tnew != 2'd0));
        hz_rt = uses_rt(bus.d_br_op) && (bus.d_rt != 5'd0) &&
                ((bus.e_wreg == bus.d_rt && bus.e_tnew != 2'd0) ||
                 (bus.m_wreg == bus.d_rt && bus.m_tnew != 2'd0));
        bus.stall = bus.d_valid && is_br && (hz_rs || hz_rt);
    end

    br_cmp u_cmp (
        .a       (op_a),
        .b       (op_b),
        .ab_code (ab_code),
        .az_code (az_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Any cycle without stall (hazard cleared, d_valid dropped, non-branch) returns to IDLE.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (bus.stall) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = CW'(1);
                end else begin
                    wait_cnt_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (bus.stall) begin
                    if (wait_cnt != CW'(WAIT_MAX))
                        wait_cnt_nxt = wait_cnt + CW'(1);
                end else begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        case (bus.d_br_op)
            BR_BEQ:  cond = (ab_code == CMP_EQ);
            BR_BNE:  cond = (ab_code != CMP_EQ);
            BR_BLEZ: cond = (az_code != CMP_GT);
            BR_BGTZ: cond = (az_code == CMP_GT);
            BR_BLTZ: cond = (az_code == CMP_LT);
            BR_BGEZ: cond = (az_code != CMP_LT);
            default: cond = 1'b0;
        endcase
        resolve      = bus.d_valid && is_br && !bus.stall;
        bus.br_taken = resolve && cond;
        wd_set       = bus.stall && (wait_cnt_nxt == CW'(WAIT_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.res_valid <= 1'b0;
            bus.res_taken <= 1'b0;
            bus.wd_err    <= 1'b0;
        end else begin
            bus.res_valid <= resolve;
            if (resolve)
                bus.res_taken <= bus.br_taken;
            if (wd_set)
                bus.wd_err <= 1'b1;
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stat_taken  <= '0;
            bus.stat_ntaken <= '0;
        end else if (resolve) begin
            if (bus.br_taken)
                bus.stat_taken  <= bus.stat_taken + 32'd1;
            else
                bus.stat_ntaken <= bus.stat_ntaken + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Bench for d_branch_ctrl: directed literal cases, then random traffic against a behavioural model.
module tb_d_branch_ctrl;

    localparam int WAIT_MAX = 3;

    logic clk;
    logic reset;

    d_branch_ctrl_if bif();

    d_branch_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state (registered view)
    logic        mr_valid = 1'b0;
    logic        mr_taken = 1'b0;
    logic        mr_wd    = 1'b0;
    int          m_run    = 0;
    logic [31:0] m_st_t   = 32'd0;
    logic [31:0] m_st_n   = 32'd0;

    // model combinational view of the current cycle
    logic exp_stall, exp_taken, exp_resolve, exp_reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_opnd(input logic [4:0] r, input logic [31:0] grf);
        if (r == 5'd0) return 32'd0;
        if (bif.e_wreg == r && bif.e_tnew == 2'd0) return bif.e_fdata;
        if (bif.m_wreg == r && bif.m_tnew == 2'd0) return bif.m_fdata;
        return grf;
    endfunction

    function automatic logic m_haz(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (bif.e_wreg == r && bif.e_tnew != 2'd0) || (bif.m_wreg == r && bif.m_tnew != 2'd0);
    endfunction

    task automatic model_eval();
        int  a, b;
        logic br, need_rt;
        br      = (bif.d_br_op >= 3'd1 && bif.d_br_op <= 3'd6);
        need_rt = (bif.d_br_op == 3'd1 || bif.d_br_op == 3'd2);
        a = int'(m_opnd(bif.d_rs, bif.rs_rdata));
        b = int'(m_opnd(bif.d_rt, bif.rt_rdata));
        exp_stall   = bif.d_valid && br && (m_haz(bif.d_rs) || (need_rt && m_haz(bif.d_rt)));
        exp_resolve = bif.d_valid && br && !exp_stall;
        case (bif.d_br_op)
            3'd1:    exp_taken = (a == b);
            3'd2:    exp_taken = (a != b);
            3'd3:    exp_taken = (a <= 0);
            3'd4:    exp_taken = (a > 0);
            3'd5:    exp_taken = (a < 0);
            3'd6:    exp_taken = (a >= 0);
            default: exp_taken = 1'b0;
        endcase
        exp_reset = reset;
    endtask

    task automatic model_check();
        model_eval();
        chk("stall", 32'(bif.stall), 32'(exp_stall));
        if (exp_resolve)
            chk("br_taken", 32'(bif.br_taken), 32'(exp_taken));
        chk("res_valid", 32'(bif.res_valid), 32'(mr_valid));
        chk("res_taken", 32'(bif.res_taken), 32'(mr_taken));
        chk("wd_err", 32'(bif.wd_err), 32'(mr_wd));
`ifdef BR_STATS_EN
        chk("stat_taken", bif.stat_taken, m_st_t);
        chk("stat_ntaken", bif.stat_ntaken, m_st_n);
`endif
    endtask

    // Inputs are driven just after a negedge; step checks, clocks the model, returns at next negedge.
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        if (exp_reset) begin
            mr_valid = 1'b0;
            mr_taken = 1'b0;
            mr_wd    = 1'b0;
            m_run    = 0;
            m_st_t   = 32'd0;
            m_st_n   = 32'd0;
        end else begin
            mr_valid = exp_resolve;
            if (exp_resolve) begin
                mr_taken = exp_taken;
                if (exp_taken) m_st_t = m_st_t + 32'd1;
                else           m_st_n = m_st_n + 32'd1;
            end
            m_run = exp_stall ? m_run + 1 : 0;
            if (m_run >= WAIT_MAX) mr_wd = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bif.d_valid  = 1'b0;
        bif.d_br_op  = 3'd0;
        bif.d_rs     = 5'd0;
        bif.d_rt     = 5'd0;
        bif.rs_rdata = 32'd0;
        bif.rt_rdata = 32'd0;
        bif.e_wreg   = 5'd0;
        bif.m_wreg   = 5'd0;
        bif.e_tnew   = 2'd0;
        bif.m_tnew   = 2'd0;
        bif.e_fdata  = 32'd0;
        bif.m_fdata  = 32'd0;
    endtask

    task automatic br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt);
        bif.d_valid = 1'b1;
        bif.d_br_op = op;
        bif.d_rs    = rs;
        bif.d_rt    = rt;
    endtask

    function automatic logic [4:0] rnd_reg();
        logic [4:0] pool [4] = '{5'd0, 5'd3, 5'd8, 5'd9};
        return pool[$urandom_range(0, 3)];
    endfunction

    function automatic logic [31:0] rnd_data();
        logic [31:0] pool [4] = '{32'd0, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    function automatic logic [1:0] rnd_tnew();
        if ($urandom_range(0, 1) == 0) return 2'd0;
        return 2'($urandom_range(1, 3));
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        step();
        reset = 1'b0;

        // reset state
        #1;
        chk("rst_res_valid", 32'(bif.res_valid), 32'd0);
        chk("rst_res_taken", 32'(bif.res_taken), 32'd0);
        chk("rst_wd_err", 32'(bif.wd_err), 32'd0);
        chk("rst_stall", 32'(bif.stall), 32'd0);
        step();

        // BEQ $0,$0
        br(3'd1, 5'd0, 5'd0);
        #1;
        chk("beq0_stall", 32'(bif.stall), 32'd0);
        chk("beq0_taken", 32'(bif.br_taken), 32'd1);
        step();
        idle();
        #1;
        chk("beq0_res_valid", 32'(bif.res_valid), 32'd1);
        chk("beq0_res_taken", 32'(bif.res_taken), 32'd1);
        step();
        chk("pulse_end", 32'(bif.res_valid), 32'd0);

        // signed compare against zero
        br(3'd4, 5'd8, 5'd0);
        bif.rs_rdata = 32'hFFFF_FFFF;
        #1;
        chk("bgtz_neg", 32'(bif.br_taken), 32'd0);
        step();
        bif.d_br_op = 3'd5;
        #1;
        chk("bltz_neg", 32'(bif.br_taken), 32'd1);
        step();

        // BNE with E hazard then M forward
        idle();
        br(3'd2, 5'd8, 5'd9);
        bif.e_wreg = 5'd8;
        bif.e_tnew = 2'd1;
        #1;
        chk("bne_stall", 32'(bif.stall), 32'd1);
        step();
        bif.e_wreg   = 5'd0;
        bif.e_tnew   = 2'd0;
        bif.m_wreg   = 5'd8;
        bif.m_tnew   = 2'd0;
        bif.m_fdata  = 32'd5;
        bif.rt_rdata = 32'd5;
        #1;
        chk("bne_fwd_stall", 32'(bif.stall), 32'd0);
        chk("bne_fwd_taken", 32'(bif.br_taken), 32'd0);
        step();

        // E has priority over M
        idle();
        br(3'd1, 5'd3, 5'd3);
        bif.rs_rdata = 32'd1;
        bif.rt_rdata = 32'd2;
        bif.e_wreg   = 5'd3;
        bif.e_fdata  = 32'd7;
        bif.m_wreg   = 5'd3;
        bif.m_fdata  = 32'd9;
        #1;
        chk("eprio_taken", 32'(bif.br_taken), 32'd1);
        step();

        // watchdog: hazard held for 4 cycles
        idle();
        br(3'd6, 5'd8, 5'd0);
        bif.e_wreg = 5'd8;
        bif.e_tnew = 2'd2;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("wd_hold", 32'(bif.wd_err), (i >= WAIT_MAX) ? 32'd1 : 32'd0);
        end
        idle();
        step();
        chk("wd_sticky", 32'(bif.wd_err), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("wd_cleared", 32'(bif.wd_err), 32'd0);

        // reset during WAIT: no resolution pulse
        br(3'd6, 5'd8, 5'd0);
        bif.e_wreg = 5'd8;
        bif.e_tnew = 2'd1;
        step();
        step();
        bif.e_wreg = 5'd0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        chk("rst_wait_no_pulse", 32'(bif.res_valid), 32'd0);
        step();

        // 3 taken + 2 not-taken from a clean reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            br((i < 3) ? 3'd1 : 3'd2, 5'd0, 5'd0);
            step();
        end
        idle();
        step();
`ifdef BR_STATS_EN
        chk("stat_taken_3", bif.stat_taken, 32'd3);
        chk("stat_ntaken_2", bif.stat_ntaken, 32'd2);
`endif

        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 149) == 0);
            bif.d_valid  = ($urandom_range(0, 4) != 0);
            bif.d_br_op  = 3'($urandom_range(0, 7));
            bif.d_rs     = rnd_reg();
            bif.d_rt     = rnd_reg();
            bif.rs_rdata = rnd_data();
            bif.rt_rdata = rnd_data();
            bif.e_wreg   = rnd_reg();
            bif.m_wreg   = rnd_reg();
            bif.e_tnew   = rnd_tnew();
            bif.m_tnew   = rnd_tnew();
            bif.e_fdata  = rnd_data();
            bif.m_fdata  = rnd_data();
            // occasionally hold a hazard to exercise the watchdog
            if ($urandom_range(0, 19) == 0) begin
                bif.d_valid = 1'b1;
                bif.d_br_op = 3'd3;
                bif.d_rs    = 5'd9;
                bif.e_wreg  = 5'd9;
                bif.e_tnew  = 2'd3;
                reset       = 1'b0;
                for (int k = 0; k < 4; k++) step();
            end else begin
                step();
            end
        end
        reset = 1'b0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
